// File: rtl/reel_pkg.sv
// Shared definitions for the reel encoder front end: quadrature state codes,
// the clockwise successor lookup and the transition classifier.
package reel_pkg;

    localparam int REEL_W = 14;

    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q01 = 2'b01;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q10 = 2'b10;

    typedef enum logic [1:0] {
        DEC_NONE    = 2'd0,
        DEC_CW      = 2'd1,
        DEC_CCW     = 2'd2,
        DEC_ILLEGAL = 2'd3
    } dec_kind_e;

    function automatic logic [1:0] cw_next(input logic [1:0] s);
        case (s)
            Q00:     return Q01;
            Q01:     return Q11;
            Q11:     return Q10;
            default: return Q00;
        endcase
    endfunction

    // A two-bit jump (both channels flipped) cannot be attributed to a direction.
    function automatic dec_kind_e classify(input logic [1:0] prev, input logic [1:0] cur);
        if (cur == prev)               return DEC_NONE;
        else if (cur == cw_next(prev)) return DEC_CW;
        else if (prev == cw_next(cur)) return DEC_CCW;
        else                           return DEC_ILLEGAL;
    endfunction

endpackage

// File: rtl/quad_debounce.sv
// One encoder channel: two-flop synchroniser followed by a level debouncer that
// pulses changed whenever a new level is accepted (including the first one after reset).
module quad_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level_out,
    output logic changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    logic             settled;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            level_out <= 1'b0;
            settled   <= 1'b0;
            cnt       <= '0;
            changed   <= 1'b0;
        end else begin
            sync1   <= raw_in;
            sync2   <= sync1;
            changed <= 1'b0;
            if (!settled) begin
                // After reset the level is unknown: track the sample and accept it once stable.
                if (sync2 != level_out) begin
                    level_out <= sync2;
                    cnt       <= '0;
                end else if (cnt == CNT_DONE) begin
                    settled <= 1'b1;
                    cnt     <= '0;
                    changed <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (sync2 != level_out) begin
                if (cnt == CNT_DONE) begin
                    level_out <= sync2;
                    cnt       <= '0;
                    changed   <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/reel_encoder_frontend.sv
// Quadrature reel crank front end: debounced channels, direction decode and a
// saturating credit accumulator drained by the game tick.
module reel_encoder_frontend
    import reel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int STEP_CREDIT     = 4,
    parameter int DECAY           = 1,
    parameter int CREDIT_MAX      = 16383
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        tick,
    output logic [13:0] reel,
    output logic        step_valid,
    output logic        step_dir,
    output logic        err
);

    localparam logic signed [15:0] STEP_S = 16'(STEP_CREDIT);
    localparam logic signed [15:0] DECAY_S = 16'(DECAY);
    localparam logic signed [15:0] MAX_S = 16'(CREDIT_MAX);

    logic              lvl_a;
    logic              lvl_b;
    logic              chg_a;
    logic              chg_b;
    logic              primed;
    logic [1:0]        prev_ab;
    logic [1:0]        cur_ab;
    dec_kind_e         kind;
    logic signed [15:0] acc_next;
    logic [REEL_W-1:0] reel_next;

    quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (enc_a),
        .level_out (lvl_a),
        .changed   (chg_a)
    );

    quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (enc_b),
        .level_out (lvl_b),
        .changed   (chg_b)
    );

    assign cur_ab = {lvl_a, lvl_b};
    assign kind   = classify(prev_ab, cur_ab);

    // Net the step credit and tick decay first, then clamp once.
    always_comb begin
        acc_next = $signed({2'b00, reel});
        if (step_valid && step_dir) acc_next = acc_next + STEP_S;
        if (tick)                   acc_next = acc_next - DECAY_S;
        if (acc_next < 0)           reel_next = '0;
        else if (acc_next > MAX_S)  reel_next = REEL_W'(CREDIT_MAX);
        else                        reel_next = acc_next[REEL_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reel       <= '0;
            step_valid <= 1'b0;
            step_dir   <= 1'b0;
            err        <= 1'b0;
            primed     <= 1'b0;
            prev_ab    <= Q00;
        end else begin
            step_valid <= 1'b0;
            step_dir   <= 1'b0;
            err        <= 1'b0;
            reel       <= reel_next;
            // Channels accepted in the same cycle fold into a single transition.
            if (chg_a || chg_b) begin
                prev_ab <= cur_ab;
                if (!primed) begin
                    primed <= 1'b1;
                end else begin
                    case (kind)
                        DEC_CW: begin
                            step_valid <= 1'b1;
                            step_dir   <= 1'b1;
                        end
                        DEC_CCW:     step_valid <= 1'b1;
                        DEC_ILLEGAL: err <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
